// File: rtl/systolic_feeder_if.sv
// Operand write port and skewed row/column stream outputs of the systolic-array feeder.
interface systolic_feeder_if #(
    parameter int unsigned DATA_SIZE = 32
);
    logic                        wr_en;
    logic                        wr_sel;
    logic [3:0]                  wr_addr;
    logic signed [DATA_SIZE-1:0] wr_data;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        arr_clr;
    logic signed [DATA_SIZE-1:0] a1, a2, a3, a4;
    logic signed [DATA_SIZE-1:0] b1, b2, b3, b4;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, done, arr_clr, a1, a2, a3, a4, b1, b2, b3, b4
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, done, arr_clr, a1, a2, a3, a4, b1, b2, b3, b4
    );
endinterface

// File: rtl/systolic_feeder.sv
// Holds 4x4 operands A and B, clears the systolic array, then streams
// diagonally skewed rows of A and columns of B into it.
module systolic_feeder #(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic             clk,
    input  logic             reset,
    systolic_feeder_if.slave bus
);
    localparam int unsigned N          = 4;
    localparam int unsigned NE         = N * N;
    localparam int unsigned TW         = 4;
    localparam int unsigned STREAM_LEN = 10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        t_q, t_d;
    logic [DATA_SIZE-1:0] mem_a_q [NE];
    logic [DATA_SIZE-1:0] mem_a_d [NE];
    logic [DATA_SIZE-1:0] mem_b_q [NE];
    logic [DATA_SIZE-1:0] mem_b_d [NE];
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 clr_q, clr_d;
    logic [DATA_SIZE-1:0] a_q [N];
    logic [DATA_SIZE-1:0] a_d [N];
    logic [DATA_SIZE-1:0] b_q [N];
    logic [DATA_SIZE-1:0] b_d [N];
    logic [TW-1:0]        skew_k;

    // Sequencing: one CLEAR cycle, STREAM_LEN stream steps, one DONE cycle.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                t_d     = '0;
            end
            S_STREAM: begin
                if (t_q == TW'(STREAM_LEN - 1)) state_d = S_DONE;
                else                            t_d     = t_q + TW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand storage is writable only while idle.
    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        if ((state_q == S_IDLE) && bus.wr_en) begin
            if (bus.wr_sel) mem_b_d[bus.wr_addr] = bus.wr_data;
            else            mem_a_d[bus.wr_addr] = bus.wr_data;
        end
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        clr_d  = (state_d == S_CLEAR);
        skew_k = '0;
        for (int unsigned i = 0; i < N; i++) begin
            a_d[i] = '0;
            b_d[i] = '0;
        end
        if (state_d == S_STREAM) begin
            for (int unsigned i = 0; i < N; i++) begin
                skew_k = t_d - TW'(i);
                if ((t_d >= TW'(i)) && (skew_k < TW'(N))) begin
                    a_d[i] = mem_a_q[{2'(i), skew_k[1:0]}];
                    b_d[i] = mem_b_q[{skew_k[1:0], 2'(i)}];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            for (int unsigned i = 0; i < NE; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
            for (int unsigned i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            mem_a_q <= mem_a_d;
            mem_b_q <= mem_b_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.arr_clr = clr_q;
    assign bus.a1      = a_q[0];
    assign bus.a2      = a_q[1];
    assign bus.a3      = a_q[2];
    assign bus.a4      = a_q[3];
    assign bus.b1      = b_q[0];
    assign bus.b2      = b_q[1];
    assign bus.b3      = b_q[2];
    assign bus.b4      = b_q[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed and random operand sets, stream and
// product checks against a matrix model, protocol, reset and back-to-back runs.
module tb_systolic_feeder;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_feeder_if #(.DATA_SIZE(DW)) bus ();
    systolic_feeder #(.DATA_SIZE(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int ntests = 0;
    int nfail  = 0;

    logic [DW-1:0]      ma [4][4];
    logic [DW-1:0]      mb [4][4];
    logic [DW-1:0]      na [4][4];
    logic [DW-1:0]      nb [4][4];
    longint             a_cap [4][10];
    longint             b_cap [4][10];
    logic signed [63:0] c_res [4][4];
    logic signed [63:0] c_prev [4][4];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] get_a(input int i);
        case (i)
            0: return bus.a1;
            1: return bus.a2;
            2: return bus.a3;
            default: return bus.a4;
        endcase
    endfunction

    function automatic logic [DW-1:0] get_b(input int i);
        case (i)
            0: return bus.b1;
            1: return bus.b2;
            2: return bus.b3;
            default: return bus.b4;
        endcase
    endfunction

    // Row i of A enters i cycles late; column i of B likewise.
    function automatic logic [DW-1:0] exp_a(input int i, input int t);
        int k = t - i;
        if (k >= 0 && k <= 3) return ma[i][k];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_b(input int i, input int t);
        int k = t - i;
        if (k >= 0 && k <= 3) return mb[k][i];
        return '0;
    endfunction

    task automatic check_streams_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s/a%0d", tag, i + 1), get_a(i), 0);
            check($sformatf("%s/b%0d", tag, i + 1), get_b(i), 0);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 4'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (sel) mb[addr / 4][addr % 4] = data;
        else     ma[addr / 4][addr % 4] = data;
    endtask

    // Loads na/nb, preceded by a junk write to one random element that must be overwritten.
    task automatic load();
        int ja = $urandom_range(0, 15);
        wr(1'b0, ja, $urandom);
        wr(1'b1, ja, $urandom);
        for (int e = 0; e < 16; e++) begin
            wr(1'b0, e, na[e / 4][e % 4]);
            wr(1'b1, e, nb[e / 4][e % 4]);
        end
    endtask

    task automatic run(input string tag, input bit with_wr, input bit ws, input int wa,
                       input logic [DW-1:0] wd, input bit disturb, input bit hold_start);
        logic signed [63:0] acc, refv;
        int ka, kb;
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = ws;
            bus.wr_addr = 4'(wa);
            bus.wr_data = wd;
            if (ws) mb[wa / 4][wa % 4] = wd;
            else    ma[wa / 4][wa % 4] = wd;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (!hold_start) bus.start = 1'b0;
        check({tag, "/clr_busy"}, bus.busy, 1);
        check({tag, "/clr_arr_clr"}, bus.arr_clr, 1);
        check({tag, "/clr_done"}, bus.done, 0);
        check_streams_zero({tag, "/clr"});
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check($sformatf("%s/t%0d_busy", tag, t), bus.busy, 1);
            check($sformatf("%s/t%0d_arr_clr", tag, t), bus.arr_clr, 0);
            check($sformatf("%s/t%0d_done", tag, t), bus.done, 0);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s/t%0d_a%0d", tag, t, i + 1), get_a(i), exp_a(i, t));
                check($sformatf("%s/t%0d_b%0d", tag, t, i + 1), get_b(i), exp_b(i, t));
                a_cap[i][t] = longint'($signed(get_a(i)));
                b_cap[i][t] = longint'($signed(get_b(i)));
            end
            if (disturb && t == 2) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'($urandom_range(0, 1));
                bus.wr_addr = 4'($urandom_range(0, 15));
                bus.wr_data = $urandom;
            end
            if (disturb && t == 3) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "/done"}, bus.done, 1);
        check({tag, "/done_busy"}, bus.busy, 1);
        check({tag, "/done_arr_clr"}, bus.arr_clr, 0);
        check_streams_zero({tag, "/done"});
        @(negedge clk);
        check({tag, "/idle_done"}, bus.done, 0);
        check({tag, "/idle_busy"}, bus.busy, 0);
        if (!hold_start) begin
            @(negedge clk);
            check({tag, "/idle2_busy"}, bus.busy, 0);
            check({tag, "/idle2_done"}, bus.done, 0);
        end
        // Emulate PE(i,j): a_i arrives j cycles late, b_j arrives i cycles late.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc  = 0;
                refv = 0;
                for (int s = 0; s < 16; s++) begin
                    ka = s - j;
                    kb = s - i;
                    if (ka >= 0 && ka < 10 && kb >= 0 && kb < 10) acc += a_cap[i][ka] * b_cap[j][kb];
                end
                for (int k = 0; k < 4; k++)
                    refv += longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]));
                c_res[i][j] = acc;
                check($sformatf("%s/c%0d", tag, i * 4 + j + 1), acc, refv);
            end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        reset       = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_arr_clr", bus.arr_clr, 0);
        check_streams_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // All-ones skew check
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                na[r][c] = 1;
                nb[r][c] = 1;
            end
        load();
        run("ones", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        check("ones/c1", c_res[0][0], 4);
        check("ones/c16", c_res[3][3], 4);

        // Known product 1..16
        for (int e = 0; e < 16; e++) begin
            na[e / 4][e % 4] = DW'(e + 1);
            nb[e / 4][e % 4] = DW'(e + 1);
        end
        load();
        run("seq", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        check("seq/c1_const", c_res[0][0], 90);
        check("seq/c2_const", c_res[0][1], 100);
        check("seq/c3_const", c_res[0][2], 110);
        check("seq/c4_const", c_res[0][3], 120);
        check("seq/c16_const", c_res[3][3], 600);

        // Signed full-width
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                na[r][c] = 32'hFFFF_FFFF;
                nb[r][c] = 32'h7FFF_FFFF;
            end
        load();
        run("sgn", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        check("sgn/c1_const", c_res[0][0], -64'sd8589934588);
        check("sgn/c11_const", c_res[2][2], -64'sd8589934588);

        // Random operands; the second run writes one element in the start cycle
        for (int n = 0; n < 3; n++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    na[r][c] = $urandom;
                    nb[r][c] = $urandom;
                end
            load();
            run($sformatf("rnd%0d", n), n == 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                $urandom, 1'b0, 1'b0);
        end

        // Start and write pulsed mid-stream are ignored; a rerun sees unchanged storage
        run("proto", 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
        run("proto_rerun", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);

        // Back-to-back with start held high through DONE
        run("b2b_1", 1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        c_prev = c_res;
        run("b2b_2", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b/same_c%0d", i * 5 + 1), c_res[i][i], c_prev[i][i]);

        // Asynchronous reset in the middle of the stream
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid/busy_before", bus.busy, 1);
        reset = 1'b0;
        #1;
        check("mid/busy", bus.busy, 0);
        check("mid/done", bus.done, 0);
        check("mid/arr_clr", bus.arr_clr, 0);
        check_streams_zero("mid");
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        @(negedge clk);
        run("post_rst_zero", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);

        // Identity x 1..16
        for (int e = 0; e < 16; e++) begin
            na[e / 4][e % 4] = (e / 4 == e % 4) ? DW'(1) : DW'(0);
            nb[e / 4][e % 4] = DW'(e + 1);
        end
        load();
        run("ident", 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
        for (int e = 0; e < 16; e++)
            check($sformatf("ident/c%0d_const", e + 1), c_res[e / 4][e % 4], 64'(e + 1));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
